// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/handshake/shared-bus bundle for seq_alu
interface seq_alu_if #(parameter int WIDTH = 8);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             enable;
  wire  [WIDTH-1:0] w_bus;
  logic             busy;
  logic             done;
  logic [3:0]       flags;
  modport master (output start, op, a, b, enable, input w_bus, busy, done, flags);
  modport slave  (input start, op, a, b, enable, output w_bus, busy, done, flags);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU (single-cycle ops, WIDTH-cycle shift-add multiply) with
// registered result/flags {C,V,N,Z} driven onto a tri-state bus.
module seq_alu #(parameter int WIDTH = 8) (
  input logic     clk,
  input logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, MUL, DONE} state_t;
  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, r;
  logic [3:0]         flags_q, flags_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mul_nxt;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               c, v, accept, last, write;
  logic [WIDTH:0]     sum, step;
  // Accumulator is {partial high, remaining multiplier bits}; one bit consumed per cycle
  always_comb begin
    step    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nxt = {step, acc_q[WIDTH-1:1]};
  end
  always_comb begin
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op_q)
      3'b000: begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        r   = sum[M:0];
        c   = sum[WIDTH];
        v   = (a_q[M] == b_q[M]) && (r[M] != a_q[M]);
      end
      3'b001: begin
        sum = {1'b0, a_q} + {1'b0, ~b_q} + 1'b1;
        r   = sum[M:0];
        c   = sum[WIDTH];
        v   = (a_q[M] != b_q[M]) && (r[M] != a_q[M]);
      end
      3'b010: r = a_q & b_q;
      3'b011: r = a_q | b_q;
      3'b100: r = a_q ^ b_q;
      3'b101: begin
        r = {a_q[M-1:0], 1'b0};
        c = a_q[M];
      end
      3'b110: begin
        r = {1'b0, a_q[M:1]};
        c = a_q[0];
      end
      default: begin
        r = mul_nxt[M:0];
        c = |mul_nxt[2*WIDTH-1:WIDTH];
      end
    endcase
  end
  always_comb begin
    accept  = bus.start && (state_q == IDLE || state_q == DONE);
    last    = state_q == MUL && cnt_q == CW'(WIDTH - 1);
    write   = state_q == CALC || last;
    state_d = accept ? (bus.op == 3'b111 ? MUL : CALC) :
              (state_q == CALC || last) ? DONE :
              state_q == DONE ? IDLE : state_q;
    op_d    = accept ? bus.op : op_q;
    a_d     = accept ? bus.a : a_q;
    b_d     = accept ? bus.b : b_q;
    cnt_d   = accept ? '0 : state_q == MUL ? cnt_q + 1'b1 : cnt_q;
    acc_d   = accept ? {{WIDTH{1'b0}}, bus.b} : state_q == MUL ? mul_nxt : acc_q;
    res_d   = write ? r : res_q;
    flags_d = write ? {c, v, r[M], r == '0} : flags_q;
    busy_d  = state_d == CALC || state_d == MUL;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.flags = flags_q;
  assign bus.w_bus = bus.enable ? res_q : 'z;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu against an arithmetic reference model
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  seq_alu_if #(.WIDTH(8)) bus ();
  seq_alu #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;
  vec_t dir [11];
  // Returns {C,V,N,Z,result} from plain integer arithmetic
  function automatic logic [11:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int ux, uy, sx, sy, full, s;
    logic [7:0] r;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    full = 0;
    s = 0;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0: begin full = ux + uy; s = sx + sy; c = full > 255; v = (s > 127) || (s < -128); end
      3'd1: begin full = ux - uy; s = sx - sy; c = ux >= uy; v = (s > 127) || (s < -128); end
      3'd2: full = int'(x & y);
      3'd3: full = int'(x | y);
      3'd4: full = int'(x ^ y);
      3'd5: begin full = ux * 2; c = x[7]; end
      3'd6: begin full = ux / 2; c = x[0]; end
      default: begin full = ux * uy; c = full > 255; end
    endcase
    r = full[7:0];
    return {c, v, r[7], r == 8'h00, r};
  endfunction
  // Pulses start for one cycle and waits (bounded) for done; leaves the bench at the done negedge
  task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output int nbusy);
    bit ok;
    bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
    nbusy = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1;
        break;
      end
      if (bus.busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout op=%0d got no done within 40 cycles, required done", o);
    end
  endtask
  task automatic test_reset;
    int nb;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b required 0", bus.done); end
    if (bus.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b required 0000", bus.flags); end
    if (bus.w_bus !== 8'h00) begin errors++; $display("FAIL reset_result got %h required 00", bus.w_bus); end
    rst_n = 1'b1;
    do_op(3'd0, 8'h12, 8'h34, nb);
    checks += 2;
    if (nb !== 1) begin errors++; $display("FAIL first_start_busy got %0d required 1", nb); end
    if (bus.w_bus !== 8'h46) begin errors++; $display("FAIL first_start_result got %h required 46", bus.w_bus); end
  endtask
  task automatic test_directed;
    int nb;
    dir = '{'{3'd0, 8'hFF, 8'h01, 8'h00, 4'b1001}, '{3'd1, 8'h03, 8'h01, 8'h02, 4'b1000},
            '{3'd1, 8'h01, 8'h03, 8'hFE, 4'b0010}, '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0110},
            '{3'd7, 8'h0D, 8'h0B, 8'h8F, 4'b0010}, '{3'd7, 8'h20, 8'h10, 8'h00, 4'b1001},
            '{3'd2, 8'h81, 8'h0F, 8'h01, 4'b0000}, '{3'd3, 8'h81, 8'h0F, 8'h8F, 4'b0010},
            '{3'd4, 8'h81, 8'h0F, 8'h8E, 4'b0010}, '{3'd5, 8'h81, 8'h0F, 8'h02, 4'b1000},
            '{3'd6, 8'h81, 8'h0F, 8'h40, 4'b1000}};
    for (int i = 0; i < 11; i++) begin
      do_op(dir[i].op, dir[i].a, dir[i].b, nb);
      checks += 4;
      if (bus.w_bus !== dir[i].r) begin errors++; $display("FAIL dir%0d_result got %h required %h", i, bus.w_bus, dir[i].r); end
      if (bus.flags !== dir[i].f) begin errors++; $display("FAIL dir%0d_flags got %b required %b", i, bus.flags, dir[i].f); end
      if (nb !== (dir[i].op == 3'd7 ? 8 : 1)) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d required %0d", i, nb, dir[i].op == 3'd7 ? 8 : 1); end
      @(negedge clk);
      if (bus.done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b required 0", i, bus.done); end
    end
  endtask
  task automatic test_random;
    int nb;
    logic [2:0] o;
    logic [7:0] x, y;
    logic [11:0] e;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = 8'($urandom);
      y = 8'($urandom);
      e = ref_op(o, x, y);
      do_op(o, x, y, nb);
      checks += 3;
      if (bus.w_bus !== e[7:0]) begin errors++; $display("FAIL rnd_result op=%0d a=%h b=%h got %h required %h", o, x, y, bus.w_bus, e[7:0]); end
      if (bus.flags !== e[11:8]) begin errors++; $display("FAIL rnd_flags op=%0d a=%h b=%h got %b required %b", o, x, y, bus.flags, e[11:8]); end
      if (nb !== (o == 3'd7 ? 8 : 1)) begin errors++; $display("FAIL rnd_busy_cycles op=%0d got %0d required %0d", o, nb, o == 3'd7 ? 8 : 1); end
    end
    @(negedge clk);
  endtask
  task automatic test_mul_ignore_start;
    int nb, bad;
    bit ok;
    logic [11:0] e;
    do_op(3'd0, 8'h11, 8'h22, nb);
    @(negedge clk);
    e = ref_op(3'd7, 8'hB7, 8'h5C);
    bus.start = 1'b1;
    bus.op = 3'd7;
    bus.a = 8'hB7;
    bus.b = 8'h5C;
    @(negedge clk);
    bus.start = 1'b0;
    nb = 0;
    bad = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1;
        break;
      end
      if (bus.busy === 1'b1) nb++;
      if (bus.w_bus !== 8'h33) bad++;
      bus.start = (i == 2);
      if (i == 2) begin
        bus.op = 3'd0;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks += 4;
    if (!ok) begin errors++; $display("FAIL mul_ign_done got no done required done"); end
    if (bad != 0) begin errors++; $display("FAIL mul_bus_prev got %0d cycles off 33 required 0", bad); end
    if (bus.w_bus !== e[7:0] || bus.flags !== e[11:8]) begin errors++; $display("FAIL mul_ign_result got %h/%b required %h/%b", bus.w_bus, bus.flags, e[7:0], e[11:8]); end
    if (nb !== 8) begin errors++; $display("FAIL mul_ign_busy_cycles got %0d required 8", nb); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    int nb;
    logic [11:0] e;
    do_op(3'd1, 8'h50, 8'h20, nb);
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_in_done got %b required 1", bus.done); end
    e = ref_op(3'd4, 8'hA5, 8'h3C);
    do_op(3'd4, 8'hA5, 8'h3C, nb);
    checks += 2;
    if (nb !== 1) begin errors++; $display("FAIL b2b_busy got %0d required 1", nb); end
    if (bus.w_bus !== e[7:0]) begin errors++; $display("FAIL b2b_result got %h required %h", bus.w_bus, e[7:0]); end
    e = ref_op(3'd7, 8'h0D, 8'h0B);
    do_op(3'd7, 8'h0D, 8'h0B, nb);
    checks += 2;
    if (nb !== 8) begin errors++; $display("FAIL b2b_mul_busy got %0d required 8", nb); end
    if (bus.w_bus !== e[7:0]) begin errors++; $display("FAIL b2b_mul_result got %h required %h", bus.w_bus, e[7:0]); end
    @(negedge clk);
  endtask
  task automatic test_hold_and_z;
    int nb;
    do_op(3'd3, 8'h81, 8'h0F, nb);
    repeat (5) @(negedge clk);
    checks += 3;
    if (bus.w_bus !== 8'h8F) begin errors++; $display("FAIL hold_result got %h required 8F", bus.w_bus); end
    if (bus.flags !== 4'b0010) begin errors++; $display("FAIL hold_flags got %b required 0010", bus.flags); end
    bus.enable = 1'b0;
    #1;
    if (!(bus.w_bus === 8'hzz || bus.w_bus === 8'h00)) begin errors++; $display("FAIL bus_release got %h required high-Z", bus.w_bus); end
    bus.enable = 1'b1;
    #1;
    checks++;
    if (bus.w_bus !== 8'h8F) begin errors++; $display("FAIL bus_redrive got %h required 8F", bus.w_bus); end
  endtask
  task automatic test_reset_mid_mul;
    int nb, bad;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'd7;
    bus.a = 8'h0D;
    bus.b = 8'h0B;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b required 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b required 0", bus.done); end
    if (bus.w_bus !== 8'h00) begin errors++; $display("FAIL rst_mid_result got %h required 00", bus.w_bus); end
    if (bus.flags !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags got %b required 0000", bus.flags); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.w_bus !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_abort got %0d active cycles required 0", bad); end
    do_op(3'd6, 8'h81, 8'h00, nb);
    checks++;
    if (bus.w_bus !== 8'h40 || bus.flags !== 4'b1000) begin errors++; $display("FAIL post_rst_op got %h/%b required 40/1000", bus.w_bus, bus.flags); end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_random;
    test_mul_ignore_start;
    test_back_to_back;
    test_hold_and_z;
    test_reset_mid_mul;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
